// File: rtl/aes_pkg.sv
// Shared AES-128 constants and types used by the key schedule and cipher datapath.
package aes_pkg;

    localparam int unsigned AES_KEY_W  = 128;
    localparam int unsigned AES_WORD_W = 32;
    localparam int unsigned AES_ROUNDS = 10;

    typedef logic [AES_WORD_W-1:0] aes_word_t;

    localparam logic [7:0] AES_RCON [AES_ROUNDS] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Rcon byte for a round index; indices past the last round give 0.
    // A ternary keeps an unknown index visible as X instead of silently mapping it to 0.
    function automatic logic [7:0] aes_rcon(input logic [3:0] round);
        return (round < 4'(AES_ROUNDS)) ? AES_RCON[round] : 8'h00;
    endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box (FIPS-197), purely combinational. Shared with SubBytes.
module sbox (
    input  logic [7:0] data,
    output logic [7:0] subst
);

    localparam logic [7:0] SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Table lookup.
    always_comb begin
        subst = SBOX_TABLE[data];
    end

endmodule

// File: rtl/gen_key.sv
// AES-128 single-step key expansion: key_out <= next round key of key_in for Rcon(round).
// Optional load/valid handshake enabled by defining GEN_KEY_HANDSHAKE_EN.
module gen_key
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           round,
    input  logic [AES_KEY_W-1:0] key_in,
`ifdef GEN_KEY_HANDSHAKE_EN
    input  logic                 key_load,
    output logic                 key_valid,
`endif
    output logic [AES_KEY_W-1:0] key_out
);

    aes_word_t                w0, w1, w2, w3;
    aes_word_t                rot_word;
    aes_word_t                sub_word;
    aes_word_t                t_word;
    logic [AES_KEY_W-1:0]     next_key;

    assign w0 = key_in[127:96];
    assign w1 = key_in[95:64];
    assign w2 = key_in[63:32];
    assign w3 = key_in[31:0];

    // RotWord: rotate w3 left by one byte.
    assign rot_word = {w3[23:0], w3[31:24]};

    // SubWord: one S-box per byte of the rotated word.
    for (genvar i = 0; i < 4; i++) begin : g_sub
        sbox u_sbox (
            .data  (rot_word[8*i +: 8]),
            .subst (sub_word[8*i +: 8])
        );
    end

    // Rcon injection and the running XOR chain across the four words.
    always_comb begin
        aes_word_t n0, n1, n2, n3;
        t_word   = sub_word ^ {aes_rcon(round), 24'h0};
        n0       = w0 ^ t_word;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

`ifdef GEN_KEY_HANDSHAKE_EN
    // Round-key register, updated only on load; valid tracks load one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_out   <= '0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= key_load;
            if (key_load) begin
                key_out <= next_key;
            end
        end
    end
`else
    // Round-key register, updated every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_out <= '0;
        end else begin
            key_out <= next_key;
        end
    end
`endif

endmodule

// File: tb/tb_gen_key.sv
// Self-checking bench for gen_key: FIPS-197 vectors, round-key chain, async reset,
// randomized keys/rounds against an algebraic reference model.
// Handshake checks are compiled in when GEN_KEY_HANDSHAKE_EN is defined.
module tb_gen_key;

    logic         clk;
    logic         rst;
    logic [3:0]   round;
    logic [127:0] key_in;
    logic [127:0] key_out;
`ifdef GEN_KEY_HANDSHAKE_EN
    logic         key_load;
    logic         key_valid;
`endif

    int n_checks;
    int n_pass;

    logic [7:0] sbox_ref [256];

    gen_key dut (
        .clk       (clk),
        .rst       (rst),
        .round     (round),
        .key_in    (key_in),
`ifdef GEN_KEY_HANDSHAKE_EN
        .key_load  (key_load),
        .key_valid (key_valid),
`endif
        .key_out   (key_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparison point for every check in the bench.
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        return (v << s) | (v >> (8 - s));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Rcon as successive doublings of 1 in GF(2^8); zero past round 9.
    function automatic logic [7:0] rcon_ref(input int r);
        logic [7:0] c = 8'h01;
        if (r > 9) return 8'h00;
        for (int k = 0; k < r; k++) c = gf_mul(c, 8'h02);
        return c;
    endfunction

    // One key-schedule step on a word array.
    function automatic logic [127:0] next_ref(input logic [127:0] key, input int r);
        logic [31:0] w [4];
        logic [31:0] n [4];
        logic [31:0] t;
        logic [7:0]  b [4];
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        b[0] = w[3][23:16];
        b[1] = w[3][15:8];
        b[2] = w[3][7:0];
        b[3] = w[3][31:24];
        t = {sbox_ref[b[0]] ^ rcon_ref(r), sbox_ref[b[1]], sbox_ref[b[2]], sbox_ref[b[3]]};
        n[0] = w[0] ^ t;
        for (int i = 1; i < 4; i++) n[i] = w[i] ^ n[i-1];
        return {n[0], n[1], n[2], n[3]};
    endfunction

    // Present inputs on the falling edge, then return just after the next rising edge.
    task automatic step(input logic [127:0] k, input int r);
        @(negedge clk);
        key_in = k;
        round  = 4'(r);
        @(posedge clk);
        #1;
    endtask

    logic [127:0] chain_exp [10];
    logic [127:0] k;
    int           r;

    initial begin
        chain_exp[0] = 128'ha0fafe1788542cb123a339392a6c7605;
        chain_exp[1] = 128'hf2c295f27a96b9435935807a7359f67f;
        chain_exp[2] = 128'h3d80477d4716fe3e1e237e446d7a883b;
        chain_exp[3] = 128'hef44a541a8525b7fb671253bdb0bad00;
        chain_exp[4] = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        chain_exp[5] = 128'h6d88a37a110b3efddbf98641ca0093fd;
        chain_exp[6] = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        chain_exp[7] = 128'head27321b58dbad2312bf5607f8d292f;
        chain_exp[8] = 128'hac7766f319fadc2128d12941575c006e;
        chain_exp[9] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        round    = 4'd0;
        key_in   = 128'h0;
`ifdef GEN_KEY_HANDSHAKE_EN
        key_load = 1'b1;
`endif
        build_sbox();

        // Reset holds key_out at zero across clock edges.
        key_in = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", key_out, 128'h0);
`ifdef GEN_KEY_HANDSHAKE_EN
        check("reset_valid", 128'(key_valid), 128'h0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Known-answer vectors.
        step(128'h2b7e151628aed2a6abf7158809cf4f3c, 0);
        check("kat_r0", key_out, 128'ha0fafe1788542cb123a339392a6c7605);
        step(128'ha0fafe1788542cb123a339392a6c7605, 1);
        check("kat_r1", key_out, 128'hf2c295f27a96b9435935807a7359f67f);
        step(128'hd4d1c6f87c839d87caf2b8bc11f915bc, 5);
        check("kat_r5", key_out, 128'h6d88a37a110b3efddbf98641ca0093fd);
        step(128'hac7766f319fadc2128d12941575c006e, 9);
        check("kat_r9", key_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Full schedule with key_out fed back as key_in.
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        for (int i = 0; i < 10; i++) begin
            step(k, i);
            check($sformatf("chain_r%0d", i), key_out, chain_exp[i]);
            k = key_out;
        end

        // Rounds beyond 9 use Rcon 0 but still substitute and rotate.
        step(128'h000102030405060708090a0b0c0d0e0f, 10);
        check("round10", key_out, next_ref(128'h000102030405060708090a0b0c0d0e0f, 10));
        step(128'hffeeddccbbaa99887766554433221100, 15);
        check("round15", key_out, next_ref(128'hffeeddccbbaa99887766554433221100, 15));

        // Async reset between edges, then recovery on the first edge after release.
        check("pre_async_nonzero", 128'(key_out != 128'h0), 128'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", key_out, 128'h0);
        @(negedge clk);
        rst    = 1'b0;
        key_in = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        round  = 4'd0;
        @(posedge clk);
        #1;
        check("after_reset", key_out, 128'ha0fafe1788542cb123a339392a6c7605);

        // Randomized keys and rounds against the reference model.
        for (int i = 0; i < 40; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            r = int'($urandom_range(0, 15));
            step(k, r);
            check($sformatf("rand_%0d_r%0d", i, r), key_out, next_ref(k, r));
        end

`ifdef GEN_KEY_HANDSHAKE_EN
        // Without load the key holds; with load it updates and valid follows a cycle later.
        k = key_out;
        @(negedge clk);
        key_load = 1'b0;
        key_in   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        round    = 4'd0;
        @(posedge clk);
        #1;
        check("hold_key", key_out, k);
        check("hold_valid", 128'(key_valid), 128'h0);
        @(negedge clk);
        key_load = 1'b1;
        @(posedge clk);
        #1;
        check("load_key", key_out, 128'ha0fafe1788542cb123a339392a6c7605);
        check("load_valid", 128'(key_valid), 128'h1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
